// File: rtl/axi4_sram_slv.sv
// AXI4 responder backed by a word-addressed register array.
// Read and write channels run as independent two-process FSMs with INCR/FIXED bursts.
module axi4_sram_slv #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slv_ar_valid_i,
  output logic        slv_ar_ready_o,
  input  logic [31:0] slv_ar_addr_i,
  input  logic [3:0]  slv_ar_id_i,
  input  logic [7:0]  slv_ar_len_i,
  input  logic [2:0]  slv_ar_size_i,
  input  logic [1:0]  slv_ar_burst_i,
  output logic        slv_r_valid_o,
  input  logic        slv_r_ready_i,
  output logic [31:0] slv_r_data_o,
  output logic [1:0]  slv_r_resp_o,
  output logic        slv_r_last_o,
  output logic [3:0]  slv_r_id_o,
  input  logic        slv_aw_valid_i,
  output logic        slv_aw_ready_o,
  input  logic [31:0] slv_aw_addr_i,
  input  logic [3:0]  slv_aw_id_i,
  input  logic [7:0]  slv_aw_len_i,
  input  logic [2:0]  slv_aw_size_i,
  input  logic [1:0]  slv_aw_burst_i,
  input  logic        slv_w_valid_i,
  output logic        slv_w_ready_o,
  input  logic [31:0] slv_w_data_i,
  input  logic [3:0]  slv_w_strb_i,
  input  logic        slv_w_last_i,
  output logic        slv_b_valid_o,
  input  logic        slv_b_ready_i,
  output logic [1:0]  slv_b_resp_o,
  output logic [3:0]  slv_b_id_o
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES   = 32'(DEPTH) << 2'd2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_INCR  = 2'b01;

  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // Response codes are ordered so that the numerically larger code is the worse one.
  function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst);
    logic [1:0] resp;
    if ((addr - BASE_ADDR) >= MEM_BYTES) resp = RESP_DECERR;
    else if ((size > 3'd2) || (burst >= 2'b10)) resp = RESP_SLVERR;
    else resp = RESP_OKAY;
    return resp;
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return AW'((addr - BASE_ADDR) >> 2'd2);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == BURST_INCR) ? (addr + (32'd1 << size)) : addr;
  endfunction

  logic [31:0] mem_q [DEPTH];

  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [3:0]  r_id_q, r_id_d;
  logic [7:0]  r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [2:0]  r_size_q, r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [1:0]  r_resp_s;
  logic        r_last_s;

  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [3:0]  w_id_q, w_id_d;
  logic [7:0]  w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [1:0]  b_resp_q, b_resp_d;
  logic [1:0]  w_beat_resp_s;
  logic        w_last_s;
  logic        mem_we_s;
  logic [AW-1:0] w_idx_s;

  assign r_resp_s = beat_resp(r_addr_q, r_size_q, r_burst_q);
  assign r_last_s = (r_beat_q == r_len_q);

  assign slv_ar_ready_o = (r_state_q == R_IDLE);
  assign slv_r_valid_o  = (r_state_q == R_DATA);
  assign slv_r_resp_o   = slv_r_valid_o ? r_resp_s : RESP_OKAY;
  assign slv_r_last_o   = slv_r_valid_o & r_last_s;
  assign slv_r_id_o     = r_id_q;
  assign slv_r_data_o   = (slv_r_valid_o && (r_resp_s == RESP_OKAY)) ?
                          mem_q[word_idx(r_addr_q)] : 32'd0;

  // Read FSM next state: latch AR, then stream one beat per R handshake.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    case (r_state_q)
      R_IDLE: begin
        if (slv_ar_valid_i) begin
          r_addr_d  = slv_ar_addr_i;
          r_id_d    = slv_ar_id_i;
          r_len_d   = slv_ar_len_i;
          r_size_d  = slv_ar_size_i;
          r_burst_d = slv_ar_burst_i;
          r_beat_d  = 8'd0;
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (slv_r_ready_i && r_last_s) begin
          r_state_d = R_IDLE;
        end else if (slv_r_ready_i) begin
          r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
          r_beat_d = r_beat_q + 8'd1;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= 32'd0;
      r_id_q    <= 4'd0;
      r_len_q   <= 8'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      r_beat_q  <= 8'd0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
    end
  end

  assign w_beat_resp_s  = beat_resp(w_addr_q, w_size_q, w_burst_q);
  assign w_last_s       = (w_beat_q == w_len_q);
  assign w_idx_s        = word_idx(w_addr_q);
  assign mem_we_s       = (w_state_q == W_DATA) && slv_w_valid_i && (w_beat_resp_s == RESP_OKAY);
  assign slv_aw_ready_o = (w_state_q == W_IDLE);
  assign slv_w_ready_o  = (w_state_q == W_DATA);
  assign slv_b_valid_o  = (w_state_q == W_RESP);
  assign slv_b_resp_o   = slv_b_valid_o ? b_resp_q : RESP_OKAY;
  assign slv_b_id_o     = w_id_q;

  // Write FSM next state; a w_last that disagrees with the beat count only degrades B.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;
    b_resp_d  = b_resp_q;
    case (w_state_q)
      W_IDLE: begin
        if (slv_aw_valid_i) begin
          w_addr_d  = slv_aw_addr_i;
          w_id_d    = slv_aw_id_i;
          w_len_d   = slv_aw_len_i;
          w_size_d  = slv_aw_size_i;
          w_burst_d = slv_aw_burst_i;
          w_beat_d  = 8'd0;
          b_resp_d  = RESP_OKAY;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (slv_w_valid_i) begin
          b_resp_d = worst(worst(b_resp_q, w_beat_resp_s),
                           (slv_w_last_i != w_last_s) ? RESP_SLVERR : RESP_OKAY);
          if (w_last_s) begin
            w_state_d = W_RESP;
          end else begin
            w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
            w_beat_d = w_beat_q + 8'd1;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (slv_b_ready_i) w_state_d = W_IDLE;
        else w_state_d = W_RESP;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= 32'd0;
      w_id_q    <= 4'd0;
      w_len_q   <= 8'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      w_beat_q  <= 8'd0;
      b_resp_q  <= 2'd0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_beat_q  <= w_beat_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Byte-lane memory write; the array is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (slv_w_strb_i[b]) mem_q[w_idx_s][8*b +: 8] <= slv_w_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_sram_slv.sv
// Directed, table-driven bench for axi4_sram_slv plus hand-written multi-cycle sequences.
module tb_axi4_sram_slv;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ar_valid = 1'b0, ar_ready;
  logic [31:0] ar_addr = 32'd0;
  logic [3:0]  ar_id = 4'd0;
  logic [7:0]  ar_len = 8'd0;
  logic [2:0]  ar_size = 3'd0;
  logic [1:0]  ar_burst = 2'd0;
  logic        r_valid, r_ready = 1'b0, r_last;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic [3:0]  r_id;
  logic        aw_valid = 1'b0, aw_ready;
  logic [31:0] aw_addr = 32'd0;
  logic [3:0]  aw_id = 4'd0;
  logic [7:0]  aw_len = 8'd0;
  logic [2:0]  aw_size = 3'd0;
  logic [1:0]  aw_burst = 2'd0;
  logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
  logic [31:0] w_data = 32'd0;
  logic [3:0]  w_strb = 4'd0;
  logic        b_valid, b_ready = 1'b0;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  int tests = 0;
  int fails = 0;

  axi4_sram_slv dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready), .slv_ar_addr_i(ar_addr),
    .slv_ar_id_i(ar_id), .slv_ar_len_i(ar_len), .slv_ar_size_i(ar_size), .slv_ar_burst_i(ar_burst),
    .slv_r_valid_o(r_valid), .slv_r_ready_i(r_ready), .slv_r_data_o(r_data),
    .slv_r_resp_o(r_resp), .slv_r_last_o(r_last), .slv_r_id_o(r_id),
    .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(aw_ready), .slv_aw_addr_i(aw_addr),
    .slv_aw_id_i(aw_id), .slv_aw_len_i(aw_len), .slv_aw_size_i(aw_size), .slv_aw_burst_i(aw_burst),
    .slv_w_valid_i(w_valid), .slv_w_ready_o(w_ready), .slv_w_data_i(w_data),
    .slv_w_strb_i(w_strb), .slv_w_last_i(w_last),
    .slv_b_valid_o(b_valid), .slv_b_ready_i(b_ready), .slv_b_resp_o(b_resp), .slv_b_id_o(b_id)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [31:0] data0;
    logic [31:0] step;
    logic [3:0]  strb;
    int          bad_last;
    logic        bp;
    logic [1:0]  resp0;
    logic [1:0]  resp_n;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, got no handshake, required one", name);
  endtask

  task automatic do_write(input vec_t v, input string tag);
    int t;
    @(negedge clk_i);
    aw_valid = 1'b1; aw_addr = v.addr; aw_id = v.id; aw_len = v.len;
    aw_size = v.size; aw_burst = v.burst;
    t = 0;
    while (!aw_ready && t < 50) begin @(negedge clk_i); t++; end
    if (!aw_ready) timeout({tag, "_aw"});
    @(posedge clk_i); @(negedge clk_i);
    aw_valid = 1'b0;
    check({tag, "_w_ready_lat"}, 32'(w_ready), 32'd1);
    for (int i = 0; i <= int'(v.len); i++) begin
      w_valid = 1'b1;
      w_data  = v.data0 + v.step * i;
      w_strb  = v.strb;
      w_last  = ((i == int'(v.len)) != (i == v.bad_last));
      t = 0;
      while (!w_ready && t < 50) begin @(negedge clk_i); t++; end
      if (!w_ready) timeout({tag, "_w"});
      @(posedge clk_i); @(negedge clk_i);
    end
    w_valid = 1'b0; w_last = 1'b0;
    check({tag, "_b_valid_lat"}, 32'(b_valid), 32'd1);
    t = 0;
    while (!b_valid && t < 50) begin @(negedge clk_i); t++; end
    if (!b_valid) timeout({tag, "_b"});
    check({tag, "_b_resp"}, 32'(b_resp), 32'(v.resp0));
    check({tag, "_b_id"}, 32'(b_id), 32'(v.id));
    b_ready = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    b_ready = 1'b0;
    check({tag, "_aw_ready_after"}, 32'(aw_ready), 32'd1);
  endtask

  task automatic do_read(input vec_t v, input string tag);
    int t, n, cyc;
    logic held;
    logic [31:0] hold_data;
    logic [1:0] hold_resp, exp_resp;
    logic hold_last;
    @(negedge clk_i);
    ar_valid = 1'b1; ar_addr = v.addr; ar_id = v.id; ar_len = v.len;
    ar_size = v.size; ar_burst = v.burst;
    t = 0;
    while (!ar_ready && t < 50) begin @(negedge clk_i); t++; end
    if (!ar_ready) timeout({tag, "_ar"});
    @(posedge clk_i); @(negedge clk_i);
    ar_valid = 1'b0;
    check({tag, "_r_valid_lat"}, 32'(r_valid), 32'd1);
    n = 0; cyc = 0; held = 1'b0;
    hold_data = 32'd0; hold_resp = 2'd0; hold_last = 1'b0;
    while (n <= int'(v.len) && cyc < 100) begin
      r_ready = v.bp ? ((cyc % 2) == 0) : 1'b1;
      if (held) begin
        check($sformatf("%s_hold_valid_b%0d", tag, n), 32'(r_valid), 32'd1);
        check($sformatf("%s_hold_data_b%0d", tag, n), r_data, hold_data);
        check($sformatf("%s_hold_resp_last_b%0d", tag, n), 32'({r_resp, r_last}),
              32'({hold_resp, hold_last}));
      end
      if (r_valid && r_ready) begin
        exp_resp = (n == 0) ? v.resp0 : v.resp_n;
        check($sformatf("%s_data_b%0d", tag, n), r_data,
              (exp_resp == 2'b00) ? (v.data0 + v.step * n) : 32'd0);
        check($sformatf("%s_resp_b%0d", tag, n), 32'(r_resp), 32'(exp_resp));
        check($sformatf("%s_last_b%0d", tag, n), 32'(r_last), 32'(n == int'(v.len)));
        check($sformatf("%s_id_b%0d", tag, n), 32'(r_id), 32'(v.id));
        n++;
        held = 1'b0;
      end else if (r_valid) begin
        held = 1'b1;
        hold_data = r_data; hold_resp = r_resp; hold_last = r_last;
      end else begin
        held = 1'b0;
      end
      @(posedge clk_i); @(negedge clk_i);
      cyc++;
    end
    r_ready = 1'b0;
    if (n <= int'(v.len)) timeout({tag, "_r"});
    check({tag, "_ar_ready_after"}, 32'({ar_ready, r_valid}), 32'b10);
  endtask

  initial begin
    //         wr    addr           len   size  burst  id     data0          step          strb   bad bp    resp0  resp_n
    vecs[0]  = '{1'b1, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'h3, 32'hDEAD_BEEF, 32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'h3, 32'hDEAD_BEEF, 32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0100, 8'd3, 3'd2, 2'b01, 4'h5, 32'h11,        32'h11,       4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[3]  = '{1'b0, 32'h8000_0100, 8'd3, 3'd2, 2'b01, 4'h6, 32'h11,        32'h11,       4'hF, -1, 1'b1, 2'b00, 2'b00};
    vecs[4]  = '{1'b1, 32'h8000_0200, 8'd0, 3'd2, 2'b01, 4'h1, 32'hAABB_CCDD, 32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[5]  = '{1'b1, 32'h8000_0200, 8'd0, 3'd2, 2'b01, 4'h1, 32'h1122_3344, 32'h0,        4'h5, -1, 1'b0, 2'b00, 2'b00};
    vecs[6]  = '{1'b0, 32'h8000_0200, 8'd0, 3'd2, 2'b01, 4'h1, 32'hAA22_CC44, 32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 4'h4, 32'h0,         32'h0,        4'hF, -1, 1'b0, 2'b11, 2'b11};
    vecs[8]  = '{1'b0, 32'h8000_0010, 8'd1, 3'd3, 2'b01, 4'h7, 32'h0,         32'h0,        4'hF, -1, 1'b0, 2'b10, 2'b10};
    vecs[9]  = '{1'b1, 32'h8000_0010, 8'd1, 3'd2, 2'b10, 4'h8, 32'h55,        32'h0,        4'hF, -1, 1'b0, 2'b10, 2'b10};
    vecs[10] = '{1'b0, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'h8, 32'hDEAD_BEEF, 32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[11] = '{1'b0, 32'h8000_0012, 8'd0, 3'd2, 2'b01, 4'h8, 32'hDEAD_BEEF, 32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[12] = '{1'b1, 32'h8000_0300, 8'd2, 3'd2, 2'b01, 4'hC, 32'h100,       32'h100,      4'hF,  0, 1'b0, 2'b10, 2'b10};
    vecs[13] = '{1'b0, 32'h8000_0300, 8'd2, 3'd2, 2'b01, 4'hC, 32'h100,       32'h100,      4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[14] = '{1'b1, 32'h8000_0400, 8'd2, 3'd2, 2'b00, 4'hD, 32'h1,         32'h1,        4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[15] = '{1'b0, 32'h8000_0400, 8'd1, 3'd2, 2'b00, 4'hD, 32'h3,         32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b00};
    vecs[16] = '{1'b1, 32'h8000_3FFC, 8'd1, 3'd2, 2'b01, 4'hE, 32'hCAFE_0000, 32'h1,        4'hF, -1, 1'b0, 2'b11, 2'b11};
    vecs[17] = '{1'b0, 32'h8000_3FFC, 8'd1, 3'd2, 2'b01, 4'hE, 32'hCAFE_0000, 32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b11};
    vecs[18] = '{1'b0, 32'h8000_0100, 8'd3, 3'd0, 2'b01, 4'hF, 32'h11,        32'h0,        4'hF, -1, 1'b0, 2'b00, 2'b00};

    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'({ar_ready, aw_ready}), 32'b11);
    check("rst_valid", 32'({r_valid, r_last, w_ready, b_valid}), 32'b0000);
    check("rst_resp", 32'({r_resp, b_resp}), 32'd0);
    check("rst_id", 32'({r_id, b_id}), 32'd0);
    rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) do_write(vecs[i], $sformatf("v%0d", i));
      else do_read(vecs[i], $sformatf("v%0d", i));
    end

    // Simultaneous AR and AW to the same word; the read beat sees the old value.
    @(negedge clk_i);
    ar_valid = 1'b1; ar_addr = 32'h8000_0010; ar_id = 4'h9; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01;
    aw_valid = 1'b1; aw_addr = 32'h8000_0010; aw_id = 4'hA; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'b01;
    check("sim_both_ready", 32'({ar_ready, aw_ready}), 32'b11);
    @(posedge clk_i); @(negedge clk_i);
    ar_valid = 1'b0; aw_valid = 1'b0;
    check("sim_both_accepted", 32'({r_valid, w_ready}), 32'b11);
    check("sim_old_data", r_data, 32'hDEAD_BEEF);
    w_valid = 1'b1; w_data = 32'h0000_0077; w_strb = 4'hF; w_last = 1'b1; r_ready = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    w_valid = 1'b0; w_last = 1'b0; r_ready = 1'b0;
    check("sim_r_done_b_valid", 32'({r_valid, b_valid}), 32'b01);
    check("sim_b_resp_id", 32'({b_resp, b_id}), 32'({2'b00, 4'hA}));
    b_ready = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    b_ready = 1'b0;
    do_read('{1'b0, 32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'h2, 32'h0000_0077, 32'h0, 4'hF, -1, 1'b0, 2'b00, 2'b00},
            "sim_new");

    // Reset asserted during beat 1 of a len=3 read.
    @(negedge clk_i);
    ar_valid = 1'b1; ar_addr = 32'h8000_0100; ar_id = 4'h2; ar_len = 8'd3; ar_size = 3'd2; ar_burst = 2'b01;
    @(posedge clk_i); @(negedge clk_i);
    ar_valid = 1'b0; r_ready = 1'b1;
    check("rmb_beat0", r_data, 32'h11);
    @(posedge clk_i); @(negedge clk_i);
    check("rmb_beat1", r_data, 32'h22);
    #1 rst_i = 1'b0;
    #1;
    check("rmb_abort", 32'({r_valid, ar_ready}), 32'b01);
    r_ready = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    do_read('{1'b0, 32'h8000_0100, 8'd1, 3'd2, 2'b01, 4'h4, 32'h11, 32'h11, 4'hF, -1, 1'b0, 2'b00, 2'b00},
            "rmb_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_sram_slv.md
# axi4_sram_slv

AXI4 responder (slave) holding a word-addressed register-array memory: the far end of the core's `io_master_*` AR/R/AW/W/B channels, and the default target for the core's fetch and load/store traffic in simulation. Read and write channels are served by two independent FSMs, with INCR and FIXED bursts up to 256 beats. Illegal requests get a protocol-correct error response.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0.
- `DEPTH`, default 4096: memory size in 32-bit words; must be a power of two.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_i`  in  1: reset, asynchronous and active-low.
- `slv_ar_valid_i` in 1 / `slv_ar_ready_o` out 1 / `slv_ar_addr_i` in 32 / `slv_ar_id_i` in 4 / `slv_ar_len_i` in 8 / `slv_ar_size_i` in 3 / `slv_ar_burst_i` in 2: read address channel.
- `slv_r_valid_o` out 1 / `slv_r_ready_i` in 1 / `slv_r_data_o` out 32 / `slv_r_resp_o` out 2 / `slv_r_last_o` out 1 / `slv_r_id_o` out 4: read data channel.
- `slv_aw_valid_i` in 1 / `slv_aw_ready_o` out 1 / `slv_aw_addr_i` in 32 / `slv_aw_id_i` in 4 / `slv_aw_len_i` in 8 / `slv_aw_size_i` in 3 / `slv_aw_burst_i` in 2: write address channel.
- `slv_w_valid_i` in 1 / `slv_w_ready_o` out 1 / `slv_w_data_i` in 32 / `slv_w_strb_i` in 4 / `slv_w_last_i` in 1: write data channel.
- `slv_b_valid_o` out 1 / `slv_b_ready_i` in 1 / `slv_b_resp_o` out 2 / `slv_b_id_o` out 4: write response channel.

## Operation
- Read FSM states:
  - R_IDLE: `ar_ready`=1. On AR handshake, latch addr, id, len, size and burst, clear the beat counter, then go to R_DATA.
  - R_DATA: `r_valid`=1. `r_data` = mem[addr index] read combinationally. `r_last` = (beat == len). On R handshake, advance the address and beat; after the last beat, go to R_IDLE.
- Write FSM states:
  - W_IDLE: `aw_ready`=1. On AW handshake, latch the request and go to W_DATA.
  - W_DATA: `w_ready`=1. On each W handshake, write the byte lanes enabled by `w_strb`; after the beat where beat == len, go to W_RESP.
  - W_RESP: `b_valid`=1. On B handshake, go to W_IDLE.
- Address index is (addr − BASE_ADDR)[log2(DEPTH)+1:2]. Unaligned addresses are truncated to the containing word.
- Address advance:
  - INCR (2'b01): addr += 1<<size.
  - FIXED (2'b00): addr unchanged.
- Error classification is evaluated per beat at the current address:
  - DECERR (2'b11): current address outside [BASE_ADDR, BASE_ADDR+4·DEPTH). Read data is 0 and the write is suppressed.
  - SLVERR (2'b10) for the whole burst: size > 2, or burst ∈ {WRAP, reserved}. All beats are still transferred (len+1 R beats or len+1 W beats); data is 0 and writes are suppressed.
  - OKAY (2'b00) otherwise.
- B response is the worst response over the burst, with DECERR > SLVERR > OKAY.
- The burst ends on the counted beat, never on `w_last`. If `w_last` does not match (beat == len) on any beat, the B response is at least SLVERR; data is still written.
- `r_id` and `b_id` echo the latched AR/AW id.
- The two FSMs are fully independent; no ordering between reads and writes is guaranteed.
- Memory array is not reset.

## Timing
- Reset values:
  - `ar_ready`=1, `aw_ready`=1.
  - `r_valid`, `r_last`, `w_ready`, `b_valid`=0.
  - `r_resp`, `b_resp`=0; `r_id`, `b_id`=0.
  - `r_data` is don't-care while `r_valid`=0.
- Reset assertion mid-burst immediately aborts both FSMs to IDLE. No B response is issued for the aborted write; beats already written stay written.
- Reads:
  - AR handshake at edge T: first `r_valid` at T+1.
  - One beat per cycle while `r_ready`=1.
  - `r_valid` and `r_data`/`r_resp`/`r_last` hold stable while `r_ready`=0.
  - After the last R handshake: `ar_ready`=1 in the following cycle (one bubble).
  - Minimum read latency is 1 cycle; throughput for a len=L burst is L+2 cycles.
- Writes:
  - AW handshake at T: `w_ready` at T+1.
  - Memory updates at the edge of each W handshake.
  - `b_valid` in the cycle after the last W handshake; held until `b_ready`.
  - `aw_ready`=1 in the cycle after the B handshake.
- Same-cycle read and write to the same word: the read returns the old value; the new value is visible from the next cycle.
- W data presented before the AW handshake is not accepted, because `w_ready`=0 in W_IDLE.
- Outputs never depend combinationally on the corresponding `*_valid_i`/`*_ready_i` of the same channel, with one exception: `r_data` follows the internal address register.

## Test plan
- Single write then read:
  - Stimulus: AW addr 0x8000_0010, len 0, size 2, INCR, id 3; W 0xDEADBEEF, strb 4'hF, last 1; then AR to the same address.
  - Required response: B resp 0 id 3; R data 0xDEADBEEF, last 1, id 3, resp 0.
- INCR burst with backpressure:
  - Stimulus: write 4 beats 0x11..0x44 at 0x8000_0100; read back len 3 with `r_ready` toggling 1,0,1,0.
  - Required response: data 0x11,0x22,0x33,0x44 in order; each beat held stable through `r_ready`=0; `r_last` only on beat 3.
- Byte strobes:
  - Stimulus: preload 0xAABBCCDD; write 0x11223344 with strb 4'b0101.
  - Required response: read returns 0xAA22CC44.
- Errors:
  - AR addr 0x7FFF_FFFC: R resp 2'b11, data 0.
  - AR size 3, len 1: two beats, both resp 2'b10.
  - AW burst WRAP, len 1: two W beats accepted, memory unchanged, B resp 2'b10.
- Protocol corner cases:
  - `w_last`=1 on beat 0 of a len=2 burst: all 3 beats accepted and written, B resp 2'b10.
  - Simultaneous AR and AW in the same cycle: both accepted at the same edge.
- Reset mid-burst:
  - Stimulus: drop `rst_i` during beat 1 of a read with len 3.
  - Required response: `r_valid`=0 and `ar_ready`=1 immediately; a new AR after release is served normally.
